// File: rtl/regfile_scoreboard.sv
// Integer register file with NREAD combinational read ports, one write port and a per-register
// busy scoreboard. Optional same-cycle write forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_scoreboard #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NREAD = 2,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREAD*AW-1:0]     rd_addr,
    output logic [NREAD*XLEN-1:0]   rd_data,
    output logic [NREAD-1:0]        rd_busy,
    input  logic                    issue_valid,
    input  logic [AW-1:0]           issue_rd,
    output logic                    issue_ready,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [XLEN-1:0]         wr_data,
    input  logic                    flush,
    output logic [AW:0]             pending_cnt
);

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [XLEN-1:0] regs_q [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             issue_set;
    logic             busy_dec;

    // Read ports; x0 reads as zero and is never busy.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int unsigned k = 0; k < NREAD; k++) begin
            if (rd_addr[k*AW +: AW] != '0) begin
                rd_data[k*XLEN +: XLEN] = regs_q[rd_addr[k*AW +: AW]];
                rd_busy[k]              = busy_q[rd_addr[k*AW +: AW]];
                if (BYPASS && wr_en && (wr_addr == rd_addr[k*AW +: AW])) begin
                    rd_data[k*XLEN +: XLEN] = wr_data;
                    rd_busy[k]              = 1'b0;
                end
            end
        end
    end

    always_comb begin
        issue_ready = (issue_rd == '0) || !busy_q[issue_rd];
        if (BYPASS && wr_en && (wr_addr == issue_rd)) begin
            issue_ready = 1'b1;
        end
    end

    assign issue_set = issue_valid && issue_ready && (issue_rd != '0) && !flush;

    // An issue to the register being written back keeps the bit set, so that clear is not counted.
    assign busy_dec = wr_en && (wr_addr != '0) && busy_q[wr_addr]
                      && !(issue_set && (wr_addr == issue_rd));

    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (issue_set) begin
            busy_d[issue_rd] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + (AW+1)'(issue_set && !busy_q[issue_rd]) - (AW+1)'(busy_dec);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr_en && (wr_addr != '0)) begin
                regs_q[wr_addr] <= wr_data;
            end
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pending_cnt = cnt_q;

endmodule
